// File: rtl/demux1t4_32_buf_pkg.sv
// Shared constants and types for the 1-to-4 buffered demultiplexer.
package demux1t4_32_buf_pkg;

  localparam int unsigned NumCh = 4;
  localparam int unsigned DefDw = 32;
  localparam int unsigned DefCw = 16;

  typedef logic [1:0] ch_sel_t;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One output channel: one-entry holding register, valid FSM and delivery counter.
module demux_slot
  import demux1t4_32_buf_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned CW = DefCw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          rdy,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [CW-1:0] cnt
);

  slot_state_e   state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          take;

  assign valid = (state_q == StFull);
  assign take  = valid & rdy;
  assign data  = data_q;
  assign cnt   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // The top only asserts wr when the slot can accept, so a full slot is
  // never overwritten while stalled.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StEmpty: if (wr) state_d = StFull;
      StFull:  if (take && !wr) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (wr) data_d = wr_data;
    if (take) cnt_d = cnt_q + CW'(1);
  end

endmodule

// File: rtl/demux1t4_32_buf.sv
// 1-to-4 demultiplexer with a one-word buffer and a delivery counter per channel.
module demux1t4_32_buf
  import demux1t4_32_buf_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned CW = DefCw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_sel,
  input  logic [DW-1:0] in_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data0,
  output logic [DW-1:0] out_data1,
  output logic [DW-1:0] out_data2,
  output logic [DW-1:0] out_data3,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3
);

  ch_sel_t          sel;
  logic [NumCh-1:0] wr;
  logic [DW-1:0]    data_arr [NumCh];
  logic [CW-1:0]    cnt_arr  [NumCh];

  assign sel      = ch_sel_t'(in_sel);
  // Readiness looks only at the addressed channel; other full channels never block.
  assign in_ready = !out_valid[sel] || out_ready[sel];

  always_comb begin
    wr = '0;
    wr[sel] = in_valid & in_ready;
  end

  for (genvar k = 0; k < NumCh; k++) begin : g_slot
    demux_slot #(
      .DW(DW),
      .CW(CW)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .wr     (wr[k]),
      .wr_data(in_data),
      .rdy    (out_ready[k]),
      .valid  (out_valid[k]),
      .data   (data_arr[k]),
      .cnt    (cnt_arr[k])
    );
  end

  assign out_data0 = data_arr[0];
  assign out_data1 = data_arr[1];
  assign out_data2 = data_arr[2];
  assign out_data3 = data_arr[3];
  assign cnt0      = cnt_arr[0];
  assign cnt1      = cnt_arr[1];
  assign cnt2      = cnt_arr[2];
  assign cnt3      = cnt_arr[3];

endmodule

// File: tb/tb_demux1t4_32_buf.sv
// Bench for demux1t4_32_buf: per-channel behavioural model plus directed literal checks.
module tb_demux1t4_32_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;

  int total = 0;
  int bad   = 0;

  demux1t4_32_buf #(
    .DW(32),
    .CW(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel is a one-word mailbox with a delivery tally.
  logic        mvalid [4];
  logic [31:0] mdata  [4];
  logic [15:0] mcnt   [4];
  logic        started = 1'b0;

  always @(posedge clk) begin
    logic        v [4];
    logic [31:0] d [4];
    logic [15:0] c [4];
    logic        acc;
    started <= 1'b1;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mvalid[k] <= 1'b0;
        mdata[k]  <= 32'h0;
        mcnt[k]   <= 16'h0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        v[k] = mvalid[k];
        d[k] = mdata[k];
        c[k] = mcnt[k];
      end
      acc = in_valid && (!mvalid[in_sel] || out_ready[in_sel]);
      for (int k = 0; k < 4; k++) begin
        if (mvalid[k] && out_ready[k]) begin
          c[k] = c[k] + 16'h1;
          v[k] = 1'b0;
        end
      end
      if (acc) begin
        v[in_sel] = 1'b1;
        d[in_sel] = in_data;
      end
      for (int k = 0; k < 4; k++) begin
        mvalid[k] <= v[k];
        mdata[k]  <= d[k];
        mcnt[k]   <= c[k];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", {28'h0, out_valid},
          {28'h0, mvalid[3], mvalid[2], mvalid[1], mvalid[0]});
      chk("data0", out_data0, mdata[0]);
      chk("data1", out_data1, mdata[1]);
      chk("data2", out_data2, mdata[2]);
      chk("data3", out_data3, mdata[3]);
      chk("cnt0", {16'h0, cnt0}, {16'h0, mcnt[0]});
      chk("cnt1", {16'h0, cnt1}, {16'h0, mcnt[1]});
      chk("cnt2", {16'h0, cnt2}, {16'h0, mcnt[2]});
      chk("cnt3", {16'h0, cnt3}, {16'h0, mcnt[3]});
      chk("in_ready", {31'h0, in_ready},
          {31'h0, (!mvalid[in_sel] || out_ready[in_sel])});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 4'h0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 4'h0);
    do_reset();
    chk("rst_valid", {28'h0, out_valid}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);

    // Single write to channel 2
    drive(1'b1, 2'd2, 32'hDEADBEEF, 4'h0);
    step();
    drive(1'b0, 2'd1, 32'h55555555, 4'h0);
    chk("w2_valid", {28'h0, out_valid}, 32'h4);
    chk("w2_data", out_data2, 32'hDEADBEEF);

    // Full channel 1 stalls, channel 3 still accepts
    drive(1'b1, 2'd1, 32'hAAAA0001, 4'h0);
    step();
    drive(1'b1, 2'd1, 32'h11111111, 4'h0);
    #1;
    chk("stall_ready", {31'h0, in_ready}, 32'h0);
    step();
    chk("stall_keep", out_data1, 32'hAAAA0001);
    drive(1'b1, 2'd3, 32'h33333333, 4'h0);
    #1;
    chk("other_ready", {31'h0, in_ready}, 32'h1);
    step();
    chk("other_valid", {28'h0, out_valid}, 32'hE);
    chk("other_data", out_data3, 32'h33333333);

    // Ignored input while in_valid is low
    drive(1'b0, 2'd0, 32'hFFFFFFFF, 4'h0);
    step();
    chk("idle_valid", {28'h0, out_valid}, 32'hE);

    // Back-to-back on channel 0
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'd0, 32'(i), 4'h1);
      #1;
      chk("b2b_ready", {31'h0, in_ready}, 32'h1);
      step();
      chk("b2b_data", out_data0, 32'(i));
    end
    drive(1'b0, 2'd0, 32'h0, 4'h1);
    step();
    chk("b2b_cnt", {16'h0, cnt0}, 32'd4);
    chk("b2b_empty", {31'h0, out_valid[0]}, 32'h0);

    // Counter wrap on channel 3
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 2'd3, 32'(i), 4'h8);
      step();
    end
    drive(1'b0, 2'd0, 32'h0, 4'h8);
    step();
    chk("wrap_pre", {16'h0, cnt3}, 32'h0000FFFF);
    drive(1'b1, 2'd3, 32'hC0FFEE00, 4'h8);
    step();
    drive(1'b0, 2'd0, 32'h0, 4'h8);
    step();
    chk("wrap_zero", {16'h0, cnt3}, 32'h0);

    // Mid-operation reset discards full channels
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 32'hA0 + 32'(k), 4'h0);
      step();
    end
    chk("fill_valid", {28'h0, out_valid}, 32'hF);
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 4'hF);
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {28'h0, out_valid}, 32'h0);
    chk("mid_rst_cnt", {cnt1, cnt3}, 32'h0);
    chk("mid_rst_data", out_data2, 32'h0);

    // All four deliver in one cycle
    drive(1'b0, 2'd0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 32'hB0 + 32'(k), 4'h0);
      step();
    end
    drive(1'b0, 2'd0, 32'h0, 4'hF);
    step();
    chk("all_valid", {28'h0, out_valid}, 32'h0);
    chk("all_cnt01", {cnt0, cnt1}, 32'h00010001);
    chk("all_cnt23", {cnt2, cnt3}, 32'h00010001);
    chk("retain", out_data0, 32'hB0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1t4_32_buf.md
DEMUX1T4_32_BUF -- requirements
Module: demux1t4_32_buf

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the data word width.
REQ-002 The block SHALL have parameter CW, default 16, giving the width of each per-channel delivery counter.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: the upstream word on in_data/in_sel is valid.
REQ-006 Port in_ready, output, 1: the block accepts the upstream word this cycle.
REQ-007 Port in_sel, input, 2: destination channel; 0..3 select channels 0..3.
REQ-008 Port in_data, input, DW: the upstream data word.
REQ-009 Port out_valid, output, 4: bit k set means channel k holds a word.
REQ-010 Port out_ready, input, 4: bit k set means the channel-k consumer takes the word this cycle.
REQ-011 Ports out_data0..out_data3, output, DW each: the held word of channels 0..3.
REQ-012 Ports cnt0..cnt3, output, CW each: words delivered on channels 0..3.

Function
REQ-013 Each channel k SHALL own a one-entry holding register with flag out_valid[k].
REQ-014 in_ready SHALL equal !out_valid[in_sel] || out_ready[in_sel]; it depends only on the selected channel, and a full channel SHALL NOT block writes to other channels.
REQ-015 An input transfer SHALL occur when in_valid && in_ready.
- On a transfer, in_data SHALL be loaded into channel in_sel and out_valid[in_sel] SHALL be 1 on the next cycle.
- Latency from input transfer to output valid SHALL be exactly 1 cycle.
REQ-016 An output transfer on channel k SHALL occur when out_valid[k] && out_ready[k].
- On an output transfer, cnt_k SHALL increment by 1, wrapping from 2^CW-1 to 0.
REQ-017 If an output transfer on channel k has no simultaneous input transfer to k, out_valid[k] SHALL clear on the next cycle.
REQ-018 If an output transfer on k and an input transfer to k occur in the same cycle, out_valid[k] SHALL stay 1 and out_data_k SHALL take the new word (back-to-back, no bubble).
REQ-019 While out_valid[k] && !out_ready[k], out_data_k SHALL stay stable.
- A write attempt to k in that state SHALL be stalled (in_ready=0) and the buffered word SHALL NOT be overwritten.
REQ-020 When out_valid[k]=0, out_data_k SHALL retain the last loaded word; it is not cleared.
REQ-021 in_sel and in_data SHALL be ignored when in_valid=0; no state change.
REQ-022 Every channel state SHALL be independent.
- At most one input transfer per cycle.
- Up to four output transfers per cycle.
REQ-023 Each channel's valid flag SHALL behave as a two-state FSM.
- EMPTY -> FULL on input transfer.
- FULL -> EMPTY on output transfer without input transfer.
- FULL -> FULL on simultaneous input and output transfer, or on no output transfer.

Reset
REQ-024 While rst=1 at a clock edge, the following SHALL be 0: out_valid, all out_data_k, all cnt_k.
REQ-025 in_ready SHALL be 1 during reset, by REQ-014 with all channels empty; no transfer SHALL be recorded while rst=1.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words without delivering them and without counting them.

Structure
REQ-027 A shared package SHALL hold the channel count (4), the default DW (32), the default CW (16), and the 2-bit channel-select typedef.
REQ-028 A sub-module demux_slot SHALL implement one channel: holding register, valid flag and counter.
- It SHALL be instantiated four times.
- The top level SHALL only decode in_sel and form in_ready.

Verification
REQ-029 Reset, then in_sel=2, in_data=32'hDEADBEEF, in_valid for 1 cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=DEADBEEF; other channels invalid.
REQ-030 Channel 1 full with out_ready[1]=0, write in_sel=1 data 32'h11111111 -> in_ready=0 and out_data1 unchanged; same cycle, a write with in_sel=3 -> accepted.
REQ-031 out_ready[0]=1 held, four consecutive writes to channel 0 (values 1,2,3,4) -> in_ready=1 every cycle, out_data0 shows 1,2,3,4 on consecutive cycles, cnt0=4 after the last consume.
REQ-032 cnt3 preloaded to 16'hFFFF by 65535 deliveries, one more delivery -> cnt3=0.
REQ-033 Channels 0..3 full, rst=1 for 1 cycle -> out_valid=0 and all counters 0 next cycle, with no output transfer counted.
REQ-034 All four out_ready=1 with all channels full, no input -> all four deliver in one cycle, each cnt_k+1, out_valid=0.
